// File: rtl/smu_dribble_model_if.sv
// Bundle between the dribbler model and its environment: IU push/pop traffic,
// the spill/fill req/ack handshake to the backing store, and occupancy/status outputs.
interface smu_dribble_model_if #(
   parameter int ENT_W = 30
);
   // Handshake: smu_req is registered and, once high, stays high with smu_we
   // stable until a single-cycle smu_ack; an ack seen while smu_req is low is ignored.
   logic             iu_push;
   logic             iu_pop;
   logic             hold_ovr;      // test hook: lets IU traffic through while smu_hold is high
   logic             smu_ack;
   logic             smu_req;
   logic             smu_we;
   logic             smu_hold;
   logic             ovr_flw_bit;
   logic             undr_flw_bit;
   logic [ENT_W-1:0] num_entries;
   logic [ENT_W-1:0] mem_entries;
   logic [31:0]      spill_count;
   logic [31:0]      fill_count;
   logic [1:0]       dbg_state;

   modport master (
      input  iu_push, iu_pop, hold_ovr, smu_ack,
      output smu_req, smu_we, smu_hold, ovr_flw_bit, undr_flw_bit,
             num_entries, mem_entries, spill_count, fill_count, dbg_state
   );

   modport slave (
      output iu_push, iu_pop, hold_ovr, smu_ack,
      input  smu_req, smu_we, smu_hold, ovr_flw_bit, undr_flw_bit,
             num_entries, mem_entries, spill_count, fill_count, dbg_state
   );
endinterface

// File: rtl/smu_dribble_model.sv
// Stack-manager dribbler model: tracks stack-cache occupancy from IU push/pop,
// spills/fills one entry at a time to a backing store and raises smu_hold.
module smu_dribble_model #(
   parameter int DEPTH     = 64,
   parameter int HIGH_MARK = 48,
   parameter int LOW_MARK  = 8,
   parameter int ENT_W     = 30
) (
   input logic                  pj_clk,
   input logic                  reset_l,
   smu_dribble_model_if.master  bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SPILL = 2'd1,
      ST_FILL  = 2'd2
   } state_e;

   localparam logic [ENT_W-1:0] DEPTH_C = ENT_W'(DEPTH);
   localparam logic [ENT_W-1:0] HIGH_C  = ENT_W'(HIGH_MARK);
   localparam logic [ENT_W-1:0] LOW_C   = ENT_W'(LOW_MARK);
   localparam logic [ENT_W-1:0] MEM_MAX = '1;

   state_e           state_q, state_d;
   logic [ENT_W-1:0] num_q, num_d;
   logic [ENT_W-1:0] mem_q, mem_d;
   logic [31:0]      spill_cnt_q, spill_cnt_d;
   logic [31:0]      fill_cnt_q, fill_cnt_d;
   logic             req_q, req_d;
   logic             we_q, we_d;
   logic             hold_q, hold_d;
   logic             ovr_q, ovr_d;
   logic             und_q, und_d;

   logic             iu_enable;
   logic             push_only;
   logic             pop_only;
   logic             acc_push;
   logic             acc_pop;
   logic             ack_v;
   logic [ENT_W-1:0] num_iu;

   // A simultaneous push and pop is a net-zero swap, accepted even when full or empty.
   always_comb begin
      iu_enable = ~hold_q | bus.hold_ovr;
      push_only = bus.iu_push & ~bus.iu_pop & iu_enable;
      pop_only  = bus.iu_pop & ~bus.iu_push & iu_enable;
      acc_push  = push_only & (num_q < DEPTH_C);
      acc_pop   = pop_only & (num_q != '0);
      num_iu    = num_q + ENT_W'(acc_push) - ENT_W'(acc_pop);
      ack_v     = bus.smu_ack & req_q;
   end

   always_comb begin
      state_d     = state_q;
      num_d       = num_iu;
      mem_d       = mem_q;
      spill_cnt_d = spill_cnt_q;
      fill_cnt_d  = fill_cnt_q;
      req_d       = req_q;
      we_d        = we_q;
      ovr_d       = ovr_q;
      und_d       = und_q;

      if (push_only && !(num_q < DEPTH_C)) begin
         ovr_d = 1'b1;
      end
      if (pop_only && (num_q == '0) && (mem_q == '0)) begin
         und_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            req_d = 1'b0;
            we_d  = 1'b0;
            if ((num_q > HIGH_C) && (mem_q != MEM_MAX)) begin
               state_d = ST_SPILL;
               req_d   = 1'b1;
               we_d    = 1'b1;
            end else if ((num_q < LOW_C) && (mem_q != '0)) begin
               state_d = ST_FILL;
               req_d   = 1'b1;
               we_d    = 1'b0;
            end
         end

         ST_SPILL: begin
            if (ack_v) begin
               // IU drained the cache under the transfer: nothing left to spill.
               if (num_iu == '0) begin
                  state_d = ST_IDLE;
                  req_d   = 1'b0;
                  we_d    = 1'b0;
               end else begin
                  num_d       = num_iu - ENT_W'(1);
                  mem_d       = mem_q + ENT_W'(1);
                  spill_cnt_d = spill_cnt_q + 32'd1;
                  if (!((num_d > HIGH_C) && (mem_d != MEM_MAX))) begin
                     state_d = ST_IDLE;
                     req_d   = 1'b0;
                     we_d    = 1'b0;
                  end
               end
            end
         end

         ST_FILL: begin
            if (ack_v) begin
               num_d      = num_iu + ENT_W'(1);
               mem_d      = mem_q - ENT_W'(1);
               fill_cnt_d = fill_cnt_q + 32'd1;
               if ((num_d >= LOW_C) || (mem_d == '0)) begin
                  state_d = ST_IDLE;
                  req_d   = 1'b0;
                  we_d    = 1'b0;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            we_d    = 1'b0;
         end
      endcase

      hold_d = (num_d == DEPTH_C) || ((num_d == '0) && (mem_d != '0));
   end

   always_ff @(posedge pj_clk or negedge reset_l) begin
      if (!reset_l) begin
         state_q     <= ST_IDLE;
         num_q       <= '0;
         mem_q       <= '0;
         spill_cnt_q <= '0;
         fill_cnt_q  <= '0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         hold_q      <= 1'b0;
         ovr_q       <= 1'b0;
         und_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         num_q       <= num_d;
         mem_q       <= mem_d;
         spill_cnt_q <= spill_cnt_d;
         fill_cnt_q  <= fill_cnt_d;
         req_q       <= req_d;
         we_q        <= we_d;
         hold_q      <= hold_d;
         ovr_q       <= ovr_d;
         und_q       <= und_d;
      end
   end

   assign bus.smu_req      = req_q;
   assign bus.smu_we       = we_q;
   assign bus.smu_hold     = hold_q;
   assign bus.ovr_flw_bit  = ovr_q;
   assign bus.undr_flw_bit = und_q;
   assign bus.num_entries  = num_q;
   assign bus.mem_entries  = mem_q;
   assign bus.spill_count  = spill_cnt_q;
   assign bus.fill_count   = fill_cnt_q;
   assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_smu_dribble_model.sv
// Bench for smu_dribble_model: vector table, directed corner sequences and a
// randomized run, all checked each cycle against an occupancy/transfer reference model.
module tb_smu_dribble_model;

   localparam int     DEPTH   = 64;
   localparam int     HIGH    = 48;
   localparam int     LOW     = 8;
   localparam int     ENT_W   = 30;
   localparam longint MEM_MAX = (longint'(1) << ENT_W) - 1;

   logic pj_clk  = 1'b0;
   logic reset_l = 1'b0;

   smu_dribble_model_if #(.ENT_W(ENT_W)) bus ();

   smu_dribble_model #(
      .DEPTH(DEPTH), .HIGH_MARK(HIGH), .LOW_MARK(LOW), .ENT_W(ENT_W)
   ) dut (
      .pj_clk (pj_clk),
      .reset_l(reset_l),
      .bus    (bus)
   );

   always #5 pj_clk = ~pj_clk;

   int checks = 0;
   int errors = 0;

   // Reference model: stack occupancy, backing-store contents and the outstanding transfer.
   typedef enum int {X_NONE, X_SPILL, X_FILL} xfer_e;
   longint m_num, m_mem, m_sc, m_fc;
   bit     m_ovr, m_und, m_hold;
   xfer_e  m_xfer;

   bit     auto_ack;
   bit     req_prev, ack_prev;
   bit     hold_seen;
   bit     first_req_taken;
   longint first_req_num;

   typedef struct {
      bit push;
      bit pop;
      bit ack;
      int exp_num;
      bit exp_und;
      bit exp_req;
   } vec_t;
   vec_t vt[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_num = 0; m_mem = 0; m_sc = 0; m_fc = 0;
      m_ovr = 0; m_und = 0; m_hold = 0;
      m_xfer = X_NONE;
   endtask

   task automatic model_step(input bit push, input bit pop, input bit ack, input bit ovr);
      bit     through;
      longint n;
      through = !m_hold || ovr;
      n = m_num;
      if (through && push && pop) begin
         n = m_num;
      end else if (through && push) begin
         if (m_num < DEPTH) n = m_num + 1;
         else m_ovr = 1;
      end else if (through && pop) begin
         if (m_num > 0) n = m_num - 1;
         else if (m_mem == 0) m_und = 1;
      end
      if (m_xfer == X_SPILL && ack) begin
         if (n == 0) begin
            m_xfer = X_NONE;
         end else begin
            n = n - 1; m_mem = m_mem + 1; m_sc = m_sc + 1;
            if (!(n > HIGH && m_mem < MEM_MAX)) m_xfer = X_NONE;
         end
      end else if (m_xfer == X_FILL && ack) begin
         n = n + 1; m_mem = m_mem - 1; m_fc = m_fc + 1;
         if (n >= LOW || m_mem == 0) m_xfer = X_NONE;
      end else if (m_xfer == X_NONE) begin
         if (m_num > HIGH && m_mem < MEM_MAX) m_xfer = X_SPILL;
         else if (m_num < LOW && m_mem > 0) m_xfer = X_FILL;
      end
      m_num  = n;
      m_hold = (n == DEPTH) || (n == 0 && m_mem > 0);
   endtask

   task automatic check_all();
      if (bus.smu_hold === 1'b1) hold_seen = 1;
      chk("num_entries", bus.num_entries, m_num);
      chk("mem_entries", bus.mem_entries, m_mem);
      chk("smu_req", bus.smu_req, (m_xfer != X_NONE));
      if (m_xfer != X_NONE) chk("smu_we", bus.smu_we, (m_xfer == X_SPILL));
      chk("smu_hold", bus.smu_hold, m_hold);
      chk("ovr_flw_bit", bus.ovr_flw_bit, m_ovr);
      chk("undr_flw_bit", bus.undr_flw_bit, m_und);
      chk("spill_count", bus.spill_count, m_sc & 64'hFFFF_FFFF);
      chk("fill_count", bus.fill_count, m_fc & 64'hFFFF_FFFF);
   endtask

   task automatic step(input bit push, input bit pop, input bit ack, input bit ovr);
      bus.iu_push  = push;
      bus.iu_pop   = pop;
      bus.smu_ack  = ack;
      bus.hold_ovr = ovr;
      model_step(push, pop, ack, ovr);
      @(posedge pj_clk);
      #1;
      check_all();
   endtask

   // Backing-store responder: acks one cycle after it first sees smu_req.
   task automatic cyc(input bit push, input bit pop);
      bit a;
      a = auto_ack && bus.smu_req && req_prev && !ack_prev;
      if (bus.smu_req && !req_prev && !first_req_taken) begin
         first_req_taken = 1;
         first_req_num   = bus.num_entries;
      end
      req_prev = bus.smu_req;
      ack_prev = a;
      step(push, pop, a, 1'b0);
   endtask

   task automatic clear_inputs();
      bus.iu_push = 0; bus.iu_pop = 0; bus.smu_ack = 0; bus.hold_ovr = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_l = 0;
      repeat (2) @(posedge pj_clk);
      #1;
      reset_l = 1;
      model_reset();
      req_prev = 0; ack_prev = 0;
      check_all();
   endtask

   initial begin
      clear_inputs();
      model_reset();
      auto_ack = 0; hold_seen = 0; first_req_taken = 0; first_req_num = 0;

      vt[0] = '{1, 0, 0, 1, 0, 0};
      vt[1] = '{1, 0, 0, 2, 0, 0};
      vt[2] = '{1, 1, 0, 2, 0, 0};
      vt[3] = '{0, 1, 0, 1, 0, 0};
      vt[4] = '{0, 1, 0, 0, 0, 0};
      vt[5] = '{1, 1, 0, 0, 0, 0};
      vt[6] = '{0, 1, 0, 0, 1, 0};
      vt[7] = '{0, 0, 0, 0, 1, 0};
      vt[8] = '{0, 0, 1, 0, 1, 0};
      vt[9] = '{1, 0, 0, 1, 1, 0};

      // Reset state and basic push/pop/underflow vectors.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(vt[i].push, vt[i].pop, vt[i].ack, 1'b0);
         chk($sformatf("vec%0d_num", i), bus.num_entries, vt[i].exp_num);
         chk($sformatf("vec%0d_und", i), bus.undr_flw_bit, vt[i].exp_und);
         chk($sformatf("vec%0d_req", i), bus.smu_req, vt[i].exp_req);
      end

      // 49 pushes with prompt acks: one spill back down to the high mark, no hold.
      do_reset();
      auto_ack = 1; hold_seen = 0; first_req_taken = 0;
      for (int i = 0; i < 49; i++) cyc(1, 0);
      for (int i = 0; i < 6; i++) cyc(0, 0);
      chk("t1_req_at_num", first_req_num, 49);
      chk("t1_num", bus.num_entries, 48);
      chk("t1_mem", bus.mem_entries, 1);
      chk("t1_spills", bus.spill_count, 1);
      chk("t1_req_idle", bus.smu_req, 0);
      chk("t1_hold_never", hold_seen, 0);

      // Ack withheld: fill to DEPTH, hold, ignored push, forced overflow.
      auto_ack = 0;
      for (int i = 0; i < 16; i++) cyc(1, 0);
      chk("t2_num_full", bus.num_entries, 64);
      chk("t2_hold", bus.smu_hold, 1);
      chk("t2_req_pending", bus.smu_req, 1);
      cyc(1, 0);
      chk("t2_num_after_held_push", bus.num_entries, 64);
      chk("t2_ovr_clear", bus.ovr_flw_bit, 0);
      step(1, 0, 0, 1);
      chk("t2_ovr_set", bus.ovr_flw_bit, 1);
      chk("t2_num_still_full", bus.num_entries, 64);

      // Fill from low occupancy.
      do_reset();
      auto_ack = 1;
      for (int i = 0; i < 53; i++) cyc(1, 0);
      for (int i = 0; i < 30; i++) cyc(0, 0);
      chk("t3_num48", bus.num_entries, 48);
      chk("t3_mem5", bus.mem_entries, 5);
      for (int i = 0; i < 38; i++) cyc(0, 1);
      chk("t3_num10", bus.num_entries, 10);
      chk("t3_mem5b", bus.mem_entries, 5);
      for (int i = 0; i < 3; i++) cyc(0, 1);
      chk("t3_num7", bus.num_entries, 7);
      cyc(0, 0);
      chk("t3_fill_req", bus.smu_req, 1);
      chk("t3_fill_we", bus.smu_we, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0);
      chk("t3_num8", bus.num_entries, 8);
      chk("t3_mem4", bus.mem_entries, 4);
      chk("t3_fills", bus.fill_count, 1);
      chk("t3_req_idle", bus.smu_req, 0);

      // Push, pop and spill ack together at 50 entries.
      do_reset();
      auto_ack = 0;
      for (int i = 0; i < 49; i++) cyc(1, 0);
      cyc(0, 0);
      chk("t4_spill_req", bus.smu_req, 1);
      cyc(1, 0);
      chk("t4_num50", bus.num_entries, 50);
      step(1, 1, 1, 0);
      chk("t4_num49", bus.num_entries, 49);
      chk("t4_spills", bus.spill_count, 1);
      chk("t4_mem1", bus.mem_entries, 1);
      chk("t4_req_back_to_back", bus.smu_req, 1);

      // Asynchronous reset while a spill is outstanding.
      clear_inputs();
      reset_l = 0;
      #1;
      chk("t6_req_async", bus.smu_req, 0);
      chk("t6_num_async", bus.num_entries, 0);
      chk("t6_spills_async", bus.spill_count, 0);
      chk("t6_mem_async", bus.mem_entries, 0);
      model_reset();
      @(posedge pj_clk);
      #1;
      reset_l = 1;
      req_prev = 0; ack_prev = 0;
      step(0, 0, 1, 0);
      chk("t6_late_ack_req", bus.smu_req, 0);
      chk("t6_late_ack_num", bus.num_entries, 0);
      chk("t6_late_ack_spills", bus.spill_count, 0);
      step(0, 0, 0, 0);

      // Randomized traffic with alternating push-heavy/pop-heavy phases.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         bit p, q, a, o;
         if (((i / 400) % 2) == 0) begin
            p = ($urandom_range(0, 9) < 7);
            q = ($urandom_range(0, 9) < 2);
         end else begin
            p = ($urandom_range(0, 9) < 2);
            q = ($urandom_range(0, 9) < 7);
         end
         if (bus.smu_req === 1'b1) a = ($urandom_range(0, 2) == 0);
         else a = ($urandom_range(0, 7) == 0);
         o = ($urandom_range(0, 31) == 0);
         step(p, q, a, o);
      end
      clear_inputs();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
